// File: rtl/alu_control_m_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and M-extension sequencer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package alu_control_m_pkg;

   // 4-bit ALU operation codes driven onto ALUctl
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_ctl_e;

   // ALUop classes produced by the main decoder
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_BRANCH = 2'b11;

   // func7 value that marks an R-type instruction as an M-extension op
   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   // M-extension operations, indexed by func3
   typedef enum logic [2:0] {
      M_MUL    = 3'b000,
      M_MULH   = 3'b001,
      M_MULHSU = 3'b010,
      M_MULHU  = 3'b011,
      M_DIV    = 3'b100,
      M_DIVU   = 3'b101,
      M_REM    = 3'b110,
      M_REMU   = 3'b111
   } m_op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // Divide/remainder ops share the upper half of the func3 space
   function automatic logic m_is_div(input m_op_e op);
      return op inside {M_DIV, M_DIVU, M_REM, M_REMU};
   endfunction

endpackage

// File: rtl/alu_control_m_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider datapath with sign fixup and fast-path detect.
// Latency: XLEN step cycles after start; iter_result valid combinationally on the step where last is high.
// Backpressure: none internally; the parent FSM gates start/step and stalls the pipeline.
module alu_control_m_muldiv_iter
   import alu_control_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic            abort,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            fast,
   output logic [XLEN-1:0] fast_result,
   output logic            last,
   output logic [XLEN-1:0] iter_result
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   m_op_e             op;
   m_op_e             op_q;
   logic              signed_a;
   logic              signed_b;
   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              div_zero;
   logic              div_ovf;

   // Upper half holds partial product / remainder, lower half multiplier / quotient
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_nxt;
   logic [XLEN-1:0]   opd;
   logic [CW-1:0]     cnt;
   logic              neg_lo;
   logic              neg_hi;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic [XLEN:0]     div_try;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   assign op = m_op_e'(func3);

   // Operand signedness, magnitudes and fast-path conditions from the live operands
   always_comb begin
      signed_a = op inside {M_MULH, M_MULHSU, M_DIV, M_REM};
      signed_b = op inside {M_MULH, M_DIV, M_REM};
      sa       = signed_a & rs1_val[XLEN-1];
      sb       = signed_b & rs2_val[XLEN-1];
      a_mag    = sa ? -rs1_val : rs1_val;
      b_mag    = sb ? -rs2_val : rs2_val;
      div_zero = (rs2_val == '0);
      div_ovf  = (op inside {M_DIV, M_REM}) && (rs1_val == XMIN) && (rs2_val == '1);
      fast     = m_is_div(op) & (div_zero | div_ovf);
   end

   // Fast-path result: func3[1] separates REM/REMU from DIV/DIVU
   always_comb begin
      fast_result = '0;
      if (div_zero) begin
         fast_result = func3[1] ? rs1_val : '1;
      end else if (div_ovf) begin
         fast_result = func3[1] ? '0 : XMIN;
      end
   end

   // One iteration step: shift-add for multiply, trial-subtract for divide
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opd};
      div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_try = div_sh - {1'b0, opd};
      if (m_is_div(op_q)) begin
         if (!div_try[XLEN]) begin
            acc_nxt = {div_try[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_nxt = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // Sign fixup applied to the post-step accumulator so the final step's result is usable immediately
   always_comb begin
      prod = neg_lo ? -acc_nxt : acc_nxt;
      quo  = acc_nxt[XLEN-1:0];
      rem  = acc_nxt[2*XLEN-1:XLEN];
      case (op_q)
         M_MUL:           iter_result = prod[XLEN-1:0];
         M_DIV, M_DIVU:   iter_result = neg_lo ? -quo : quo;
         M_REM, M_REMU:   iter_result = neg_hi ? -rem : rem;
         default:         iter_result = prod[2*XLEN-1:XLEN];
      endcase
   end

   assign last = (cnt == CW'(1));

   // Operand capture on start, one iteration per step, counter cleared on abort
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         opd    <= '0;
         cnt    <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         op_q   <= M_MUL;
      end else if (start) begin
         op_q   <= op;
         cnt    <= CW'(XLEN);
         neg_lo <= sa ^ sb;
         neg_hi <= sa;
         if (m_is_div(op)) begin
            opd <= b_mag;
            acc <= {{XLEN{1'b0}}, a_mag};
         end else begin
            opd <= a_mag;
            acc <= {{XLEN{1'b0}}, b_mag};
         end
      end else if (abort) begin
         cnt <= '0;
      end else if (step) begin
         acc <= acc_nxt;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_control_m.sv
// EX-stage ALU control decode plus iterative M-extension multiply/divide sequencer.
// Latency: decode combinational; M ops finish XLEN+1 cycles after accept (fast paths after 1).
// Backpressure: stall holds IF/ID/EX while an M op is in flight; md_done is a one-cycle pulse.
module alu_control_m
   import alu_control_m_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit M_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic            flush,
   input  logic [1:0]      ALUop,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [3:0]      ALUctl,
   output logic            stall,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);

   md_state_e       state;
   logic            done_q;
   logic            is_m;
   logic            busy;
   logic            accept;
   logic            md_start;
   logic            md_step;
   logic            md_abort;
   logic            md_fast;
   logic            md_last;
   logic [XLEN-1:0] md_fast_res;
   logic [XLEN-1:0] md_iter_res;
   alu_ctl_e        ctl;

   assign is_m = M_EN && (ALUop == ALUOP_RTYPE) && (func7 == FUNC7_MULDIV);

   // ALU operation decode; M ops leave the ALU on ADD since its result is discarded
   always_comb begin
      ctl = ALU_ADD;
      if (!is_m) begin
         case (ALUop)
            ALUOP_BRANCH: begin
               if (func3[2:1] == 2'b11)      ctl = ALU_SLTU;
               else if (func3[2:1] == 2'b10) ctl = ALU_SLT;
               else                          ctl = ALU_SUB;
            end
            ALUOP_ADD: ctl = ALU_ADD;
            default: begin
               case (func3)
                  3'b000:  ctl = ((ALUop == ALUOP_RTYPE) && func7[5]) ? ALU_SUB : ALU_ADD;
                  3'b001:  ctl = ALU_SLL;
                  3'b010:  ctl = ALU_SLT;
                  3'b011:  ctl = ALU_SLTU;
                  3'b100:  ctl = ALU_XOR;
                  3'b101:  ctl = func7[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  ctl = ALU_OR;
                  default: ctl = ALU_AND;
               endcase
            end
         endcase
      end
   end

   assign ALUctl = ctl;

   assign busy     = (state == ST_MUL) || (state == ST_DIV);
   assign accept   = (state == ST_IDLE) && valid && is_m && !flush;
   assign md_start = accept && !md_fast;
   assign md_step  = busy && !flush;
   assign md_abort = busy && flush;

   // Hold the pipeline until the result is presented; reset overrides everything
   assign stall   = valid && is_m && !flush && (state != ST_DONE) && !rst;
   assign md_done = done_q && !flush && !rst;

   generate
      if (M_EN) begin : g_md
         alu_control_m_muldiv_iter #(
            .XLEN (XLEN)
         ) u_muldiv_iter (
            .clk         (clk),
            .rst         (rst),
            .start       (md_start),
            .step        (md_step),
            .abort       (md_abort),
            .func3       (func3),
            .rs1_val     (rs1_val),
            .rs2_val     (rs2_val),
            .fast        (md_fast),
            .fast_result (md_fast_res),
            .last        (md_last),
            .iter_result (md_iter_res)
         );
      end else begin : g_no_md
         assign md_fast     = 1'b0;
         assign md_fast_res = '0;
         assign md_last     = 1'b0;
         assign md_iter_res = '0;
      end
   endgenerate

   // Sequencer FSM with registered done flag and result
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         done_q    <= 1'b0;
         md_result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  if (md_fast) begin
                     state     <= ST_DONE;
                     done_q    <= 1'b1;
                     md_result <= md_fast_res;
                  end else begin
                     state <= m_is_div(m_op_e'(func3)) ? ST_DIV : ST_MUL;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (md_last) begin
                  state     <= ST_DONE;
                  done_q    <= 1'b1;
                  md_result <= md_iter_res;
               end
            end
            default: begin
               // DONE always retires so the same instruction cannot restart
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_m.sv
// Self-checking bench for alu_control_m: decode vectors, M-op scoreboard, fast paths and aborts.
// Latency: checks XLEN+1 stall cycles for iterative ops and 1 for fast paths.
// Backpressure: inputs held for the full stall window, released after md_done.
module tb_alu_control_m;
   import alu_control_m_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        flush;
   logic [1:0]  ALUop;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [3:0]  ALUctl;
   logic        stall;
   logic        md_done;
   logic [31:0] md_result;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [1:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      alu_ctl_e   ctl;
      string      nm;
   } dec_vec_t;

   dec_vec_t dec_tab[15];

   alu_control_m #(
      .XLEN (32),
      .M_EN (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .flush     (flush),
      .ALUop     (ALUop),
      .func3     (func3),
      .func7     (func7),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .ALUctl    (ALUctl),
      .stall     (stall),
      .md_done   (md_done),
      .md_result (md_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one M op, push its expected result, pop and compare when md_done fires
   task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc, input string nm);
      int          stalls;
      int          done_at;
      logic [31:0] want;
      stalls  = 0;
      done_at = -1;
      valid   = 1'b1;
      flush   = 1'b0;
      ALUop   = ALUOP_RTYPE;
      func7   = FUNC7_MULDIV;
      func3   = f3;
      rs1_val = a;
      rs2_val = b;
      exp_q.push_back(exp);
      for (int c = 0; c < 100 && done_at < 0; c++) begin
         #1;
         if (stall) stalls++;
         if (md_done) begin
            done_at = c;
            if (exp_q.size() == 0) begin
               check({nm, "_unexpected_done"}, 64'd1, 64'd0);
            end else begin
               want = exp_q.pop_front();
               check({nm, "_result"}, {32'd0, md_result}, {32'd0, want});
            end
         end
         next_cycle();
      end
      if (done_at < 0 && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
      end
      valid = 1'b0;
      check({nm, "_done_cycle"}, 64'(done_at), 64'(exp_cyc));
      check({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
   endtask

   initial begin
      int          n_done;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] wide;

      dec_tab[0]  = '{ALUOP_RTYPE,  3'b000, 7'h20, ALU_SUB,  "r_sub"};
      dec_tab[1]  = '{ALUOP_RTYPE,  3'b000, 7'h00, ALU_ADD,  "r_add"};
      dec_tab[2]  = '{ALUOP_ITYPE,  3'b000, 7'h20, ALU_ADD,  "i_add_f7"};
      dec_tab[3]  = '{ALUOP_ITYPE,  3'b101, 7'h20, ALU_SRA,  "i_sra"};
      dec_tab[4]  = '{ALUOP_ITYPE,  3'b101, 7'h00, ALU_SRL,  "i_srl"};
      dec_tab[5]  = '{ALUOP_BRANCH, 3'b001, 7'h00, ALU_SUB,  "br_bne"};
      dec_tab[6]  = '{ALUOP_BRANCH, 3'b100, 7'h00, ALU_SLT,  "br_blt"};
      dec_tab[7]  = '{ALUOP_BRANCH, 3'b110, 7'h00, ALU_SLTU, "br_bltu"};
      dec_tab[8]  = '{ALUOP_ADD,    3'b111, 7'h20, ALU_ADD,  "ldst_add"};
      dec_tab[9]  = '{ALUOP_RTYPE,  3'b001, 7'h00, ALU_SLL,  "r_sll"};
      dec_tab[10] = '{ALUOP_RTYPE,  3'b011, 7'h00, ALU_SLTU, "r_sltu"};
      dec_tab[11] = '{ALUOP_ITYPE,  3'b100, 7'h00, ALU_XOR,  "i_xor"};
      dec_tab[12] = '{ALUOP_RTYPE,  3'b110, 7'h00, ALU_OR,   "r_or"};
      dec_tab[13] = '{ALUOP_ITYPE,  3'b111, 7'h00, ALU_AND,  "i_and"};
      dec_tab[14] = '{ALUOP_RTYPE,  3'b111, 7'h01, ALU_ADD,  "m_remu_add"};

      // Reset with an M op presented: stall must stay low while rst is high
      rst     = 1'b1;
      valid   = 1'b1;
      flush   = 1'b0;
      ALUop   = ALUOP_RTYPE;
      func3   = 3'b000;
      func7   = FUNC7_MULDIV;
      rs1_val = 32'd7;
      rs2_val = 32'd3;
      next_cycle();
      next_cycle();
      check("reset_stall", {63'd0, stall}, 64'd0);
      check("reset_md_done", {63'd0, md_done}, 64'd0);
      check("reset_md_result", {32'd0, md_result}, 64'd0);
      valid = 1'b0;
      rst   = 1'b0;
      next_cycle();

      // Decode table with a live non-M instruction
      for (int i = 0; i < 14; i++) begin
         valid = 1'b1;
         ALUop = dec_tab[i].op;
         func3 = dec_tab[i].f3;
         func7 = dec_tab[i].f7;
         #1;
         check({"dec_", dec_tab[i].nm}, {60'd0, ALUctl}, {60'd0, dec_tab[i].ctl});
         check({"stall_", dec_tab[i].nm}, {63'd0, stall}, 64'd0);
         next_cycle();
      end
      // M encoding: ALUctl is ADD while the op is decoded (checked before it is accepted)
      valid = 1'b0;
      ALUop = dec_tab[14].op;
      func3 = dec_tab[14].f3;
      func7 = dec_tab[14].f7;
      #1;
      check({"dec_", dec_tab[14].nm}, {60'd0, ALUctl}, {60'd0, dec_tab[14].ctl});
      next_cycle();

      // Multiplies and divides, back to back
      run_m(M_MUL,   32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 33, "mul");
      run_m(M_MULH,  32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 33, "mulh");
      run_m(M_MULHU, 32'hFFFFFFFF, 32'd3, 32'h00000002, 33, "mulhu");
      run_m(M_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
      run_m(M_REM,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
      run_m(M_DIVU,  32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, "divu");

      // Fast paths
      run_m(M_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_by0");
      run_m(M_REM,  32'd5,        32'd0,        32'd5,        1, "rem_by0");
      run_m(M_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      run_m(M_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf");

      // A few random operands against 64-bit reference arithmetic
      for (int i = 0; i < 3; i++) begin
         ra   = $urandom;
         rb   = $urandom | 32'h1;
         wide = {32'd0, ra} * {32'd0, rb};
         run_m(M_MULHU, ra, rb, wide[63:32], 33, "rnd_mulhu");
         wide = $signed({{32{ra[31]}}, ra}) * $signed({32'd0, rb});
         run_m(M_MULHSU, ra, rb, wide[63:32], 33, "rnd_mulhsu");
         run_m(M_DIVU, ra, rb >> (i * 8), ra / (rb >> (i * 8)), 33, "rnd_divu");
         run_m(M_REMU, ra, rb >> (i * 8), ra % (rb >> (i * 8)), 33, "rnd_remu");
      end

      // Flush on cycle 10 of a MUL
      valid   = 1'b1;
      flush   = 1'b0;
      ALUop   = ALUOP_RTYPE;
      func7   = FUNC7_MULDIV;
      func3   = M_MUL;
      rs1_val = 32'h12345678;
      rs2_val = 32'h9;
      for (int c = 0; c < 10; c++) next_cycle();
      flush = 1'b1;
      #1;
      check("flush_stall", {63'd0, stall}, 64'd0);
      check("flush_md_done", {63'd0, md_done}, 64'd0);
      next_cycle();
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check("flush_state_idle", {62'd0, dut.state}, {62'd0, ST_IDLE});
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (md_done) n_done++;
         next_cycle();
      end
      check("flush_no_done", 64'(n_done), 64'd0);
      run_m(M_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 33, "mul_after_flush");

      // Reset in the middle of a DIV
      valid   = 1'b1;
      ALUop   = ALUOP_RTYPE;
      func7   = FUNC7_MULDIV;
      func3   = M_DIV;
      rs1_val = 32'hFFFFFFF9;
      rs2_val = 32'd2;
      for (int c = 0; c < 15; c++) next_cycle();
      rst = 1'b1;
      #1;
      check("rst_mid_stall", {63'd0, stall}, 64'd0);
      check("rst_mid_md_done", {63'd0, md_done}, 64'd0);
      next_cycle();
      rst   = 1'b0;
      valid = 1'b0;
      #1;
      check("rst_md_result", {32'd0, md_result}, 64'd0);
      check("rst_md_done", {63'd0, md_done}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_state_idle", {62'd0, dut.state}, {62'd0, ST_IDLE});
      next_cycle();
      run_m(M_MULH, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 33, "mulh_after_rst");
      run_m(M_MUL,  32'd1000,     32'd7, 32'd7000,     33, "mul_after_rst");

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
